mem_request_arbiter: RTL

- Responder side of the datapath memory interface. It accepts instruction-fetch and data load/store requests and returns the ihit/dhit and load data that the controller and datapath consume.
- It arbitrates both requesters onto the single shared RAM port (ramREN/ramWEN/ramaddr/ramstore) and waits for the RAM's ramstate handshake.
- It sits between the datapath and the RAM model. It adds a timeout watchdog and a sticky error flag so a stuck RAM cannot hang the CPU silently.

---
 rtl/mem_request_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_request_arbiter.sv
// Memory request arbiter: serves data and fetch requests from the datapath on one shared RAM port.
// Latency: the hit pulse follows the cycle in which RAM reports ACCESS, so there are at least 2 cycles from request to hit.
// Backpressure: requesters hold their request until a hit; the RAM stalls with FREE/BUSY, and a watchdog forces an error completion.
module mem_request_arbiter #(
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        mem_err
);

  // RAM status encodings
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  // The counter must be able to hold TIMEOUT_CYC-1
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DACC  = 3'd1,
    S_IACC  = 3'd2,
    S_DRESP = 3'd3,
    S_IRESP = 3'd4
  } state_t;

  state_t     state_q,    state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] iload_q,   iload_d;
  logic [31:0] dload_q,   dload_d;
  logic        ihit_q,    ihit_d;
  logic        dhit_q,    dhit_d;
  logic        err_q,     err_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;

  logic d_req;
  logic timeout_hit;
  logic ram_fail;

  // A store wins over a load when both are raised, so either strobe alone is a data request
  assign d_req       = dREN | dWEN;
  // The watchdog fires on the last allowed cycle, but only if RAM did not complete in that cycle
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign ram_fail    = (ramstate == RS_ERROR) ||
                       (((ramstate == RS_FREE) || (ramstate == RS_BUSY)) && timeout_hit);

  // RAM port drive: live request inputs in access states, held copies otherwise so the bus never floats
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = ramaddr_q;
    ramstore = ramstore_q;
    case (state_q)
      S_DACC: begin
        ramaddr  = daddr;
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramstore = dstore;
      end
      S_IACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
      end
      default: begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
      end
    endcase
  end

  // Next-state logic: arbitration, RAM handshake, watchdog and response capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    err_d      = err_q;
    ramaddr_d  = ramaddr;
    ramstore_d = ramstore;

    case (state_q)
      S_IDLE: begin
        // Data is served before fetch; the choice is locked in on entry
        if (d_req) begin
          state_d = S_DACC;
        end else if (iREN) begin
          state_d = S_IACC;
        end
      end

      S_DACC: begin
        if (!d_req) begin
          // Requester withdrew: drop the access silently, the store is not committed
          state_d = S_IDLE;
        end else if (ramstate == RS_ACCESS) begin
          if (!dWEN) begin
            dload_d = ramload;
          end
          state_d = S_DRESP;
        end else if (ram_fail) begin
          if (!dWEN) begin
            dload_d = ERR_WORD;
          end
          err_d   = 1'b1;
          state_d = S_DRESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_IACC: begin
        if (!iREN) begin
          state_d = S_IDLE;
        end else if (ramstate == RS_ACCESS) begin
          iload_d = ramload;
          state_d = S_IRESP;
        end else if (ram_fail) begin
          iload_d = ERR_WORD;
          err_d   = 1'b1;
          state_d = S_IRESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DRESP, S_IRESP: begin
        // Hit is shown for exactly one cycle, then re-arbitrate
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every access starts its watchdog from zero
    if (state_d == S_IDLE) begin
      cnt_d = '0;
    end

    ihit_d = (state_d == S_IRESP);
    dhit_d = (state_d == S_DRESP);
  end

  // State and registered outputs; reset drops any access in flight without a hit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      iload_q    <= '0;
      dload_q    <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      err_q      <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      err_q      <= err_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
    end
  end

  assign ihit    = ihit_q;
  assign dhit    = dhit_q;
  assign iload   = iload_q;
  assign dload   = dload_q;
  assign mem_err = err_q;

  // Invariants of the response and RAM handshakes
  a_one_hit: assert property (@(posedge CLK) disable iff (RST) !(ihit && dhit));
  a_ihit_pulse: assert property (@(posedge CLK) disable iff (RST) ihit |=> !ihit);
  a_dhit_pulse: assert property (@(posedge CLK) disable iff (RST) dhit |=> !dhit);
  a_ren_wen: assert property (@(posedge CLK) disable iff (RST) !(ramREN && ramWEN));

endmodule
